instruction_fetch: RTL
======================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-004 imem_req  output  1  SHALL request an instruction-memory read.
REQ-005 imem_addr  output  32  SHALL be the byte address of the requested word.
REQ-006 imem_ack  input  1  SHALL mark imem_rdata valid in this cycle.
REQ-007 imem_rdata  input  32  SHALL be the instruction word returned by memory.
REQ-008 redirect  input  1  SHALL be the branch/jump taken pulse from execute.
REQ-009 redirect_pc  input  32  SHALL be the new fetch target, sampled when redirect=1.
REQ-010 stall  input  1  SHALL mean the decode/control stage cannot accept an instruction this cycle.
REQ-011 instructionWord  output  32  SHALL be the fetched instruction driven to the control unit.
REQ-012 pc  output  32  SHALL be the address of instructionWord.
REQ-013 inst_valid  output  1  SHALL qualify instructionWord and pc.

Function
REQ-014 The block SHALL implement the three states IDLE, FETCH and HOLD, plus an internal 32-bit fetch_pc register.
REQ-015 imem_req SHALL be 1 exactly when state=FETCH, and imem_addr SHALL equal fetch_pc at all times.
REQ-016 Transition IDLE->FETCH SHALL occur unconditionally on the first clock edge after reset deasserts.
REQ-017 FETCH with imem_ack=1 and redirect=0 SHALL load instructionWord<=imem_rdata, pc<=fetch_pc, inst_valid<=1, fetch_pc<=fetch_pc+4 and go to HOLD.
REQ-018 FETCH with imem_ack=0 SHALL hold imem_addr stable and remain in FETCH; there is no timeout.
REQ-019 HOLD SHALL keep instructionWord, pc and inst_valid=1 stable while stall=1.
REQ-020 HOLD with stall=0 SHALL count as consumption: inst_valid<=0 and next state FETCH.
REQ-021 The first-edge-after-ack latency SHALL give inst_valid=1 one cycle after the ack cycle; peak throughput is one instruction per two cycles.
REQ-022 imem_ack received outside FETCH SHALL be ignored.
REQ-023 redirect=1 in any non-reset state SHALL set fetch_pc<={redirect_pc[31:2],2'b00}, inst_valid<=0 and next state FETCH.
REQ-024 redirect=1 coinciding with imem_ack=1 SHALL discard imem_rdata; instructionWord and pc SHALL remain unchanged.
REQ-025 redirect SHALL override stall, so a stalled instruction in HOLD is flushed.
REQ-026 fetch_pc arithmetic SHALL be modulo 2^32, so 32'hFFFFFFFC+4 yields 32'h00000000.
REQ-027 Priority SHALL be rst > redirect > imem_ack/stall.
REQ-028 instruction memory SHALL tolerate an outstanding request being abandoned by an address change after redirect.

Reset
REQ-029 While rst=1, the block SHALL set state=IDLE, fetch_pc=RESET_PC, pc=RESET_PC, instructionWord=32'h0, inst_valid=0 and imem_req=0.
REQ-030 rst asserted mid-transaction SHALL abandon any pending request and discard same-cycle imem_ack data.

Verification
REQ-031 Release reset, ack every request with data 32'h000000B3 -> imem_addr sequence 0,4,8; inst_valid pulses with pc=0,4,8; instructionWord=32'h000000B3.
REQ-032 Hold imem_ack=0 for 5 cycles -> imem_req=1 and imem_addr constant, then inst_valid one cycle after ack.
REQ-033 stall=1 for 3 cycles in HOLD -> instructionWord/pc/inst_valid unchanged; no new imem_req until stall drops.
REQ-034 redirect_pc=32'h00000103 with redirect=1 in the same cycle as imem_ack -> data dropped; next imem_addr=32'h00000100; inst_valid=0.
REQ-035 fetch_pc=32'hFFFFFFFC, ack -> pc=32'hFFFFFFFC; next imem_addr=32'h00000000.
REQ-036 rst=1 in FETCH with imem_ack=1 -> all outputs reach their reset values next edge; imem_addr=RESET_PC.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: IDLE/FETCH/HOLD sequencer that requests one word at a time
// and presents it to decode until it is consumed or flushed by a redirect.

module instruction_fetch_checker (
   input logic i_clk,
   input logic i_rst,
   input logic i_imem_req,
   input logic i_inst_valid,
   input logic i_in_fetch,
   input logic i_in_hold
);

   a_req_only_in_fetch : assert property (@(posedge i_clk) disable iff (i_rst)
      i_imem_req == i_in_fetch);

   a_valid_only_in_hold : assert property (@(posedge i_clk) disable iff (i_rst)
      i_inst_valid |-> i_in_hold);

endmodule

module instruction_fetch #(
   parameter logic [31:0] RESET_PC = 32'h00000000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   output logic [31:0] instructionWord,
   output logic [31:0] pc,
   output logic        inst_valid
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_fetch_pc;
   logic [31:0] w_fetch_pc_nxt;
   logic [31:0] r_instr;
   logic [31:0] w_instr_nxt;
   logic [31:0] r_pc;
   logic [31:0] w_pc_nxt;
   logic        r_valid;
   logic        w_valid_nxt;

   // Redirect targets are forced onto a word boundary.
   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_fetch_pc <= RESET_PC;
         r_pc       <= RESET_PC;
         r_instr    <= 32'h00000000;
         r_valid    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_fetch_pc <= w_fetch_pc_nxt;
         r_pc       <= w_pc_nxt;
         r_instr    <= w_instr_nxt;
         r_valid    <= w_valid_nxt;
      end
   end

   // Next-state selection; redirect wins over ack and stall.
   always_comb begin
      w_state_nxt = r_state;
      if (redirect) begin
         w_state_nxt = ST_FETCH;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
               if (imem_ack) begin
                  w_state_nxt = ST_HOLD;
               end else begin
                  w_state_nxt = ST_FETCH;
               end
            end
            ST_HOLD: begin
               if (stall) begin
                  w_state_nxt = ST_HOLD;
               end else begin
                  w_state_nxt = ST_FETCH;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // Datapath next values: capture on ack, clear valid on consume or flush.
   always_comb begin
      w_fetch_pc_nxt = r_fetch_pc;
      w_instr_nxt    = r_instr;
      w_pc_nxt       = r_pc;
      w_valid_nxt    = r_valid;
      if (redirect) begin
         w_fetch_pc_nxt = align_word(redirect_pc);
         w_valid_nxt    = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_valid_nxt = 1'b0;
            end
            ST_FETCH: begin
               if (imem_ack) begin
                  w_instr_nxt    = imem_rdata;
                  w_pc_nxt       = r_fetch_pc;
                  w_valid_nxt    = 1'b1;
                  w_fetch_pc_nxt = r_fetch_pc + 32'd4;
               end else begin
                  w_valid_nxt = 1'b0;
               end
            end
            ST_HOLD: begin
               if (stall) begin
                  w_valid_nxt = 1'b1;
               end else begin
                  w_valid_nxt = 1'b0;
               end
            end
            default: begin
               w_valid_nxt = 1'b0;
            end
         endcase
      end
   end

   assign imem_req        = (r_state == ST_FETCH);
   assign imem_addr       = r_fetch_pc;
   assign instructionWord = r_instr;
   assign pc              = r_pc;
   assign inst_valid      = r_valid;

   instruction_fetch_checker u_chk (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_imem_req   (imem_req),
      .i_inst_valid (inst_valid),
      .i_in_fetch   (r_state == ST_FETCH),
      .i_in_hold    (r_state == ST_HOLD)
   );

endmodule
